// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default operand width and the {n,z,v} flag bundle
// used by the subtractor and the ALU flag register.
package datapath_pkg;

  localparam int unsigned DATAPATH_WIDTH = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  // Signed overflow of a - b: the operands differ in sign and the result sign
  // does not follow the minuend.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor; cells chain through bin/bout into a ripple-borrow subtractor.
module full_subtractor
  import datapath_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_reg.sv
// Registered two's-complement subtractor: diff = in1 - in2 (mod 2^WIDTH) plus
// borrow/zero/overflow flags, all captured one cycle after a valid operand pair.
module subtractor_reg
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATAPATH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_c;
  flags_t           flags_c;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] diff_d, diff_q;
  flags_t           flags_d, flags_q;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor u_fs (
      .a    (in1[i]),
      .b    (in2[i]),
      .bin  (borrow[i]),
      .d    (diff_c[i]),
      .bout (borrow[i+1])
    );
  end

  // The borrow out of the top cell is exactly the unsigned (in2 > in1) compare.
  always_comb begin
    flags_c   = '0;
    flags_c.n = borrow[WIDTH];
    flags_c.z = ~|diff_c;
    flags_c.v = sub_overflow(in1[MSB], in2[MSB], diff_c[MSB]);
  end

  // Results only move on a valid cycle; otherwise the last result is held.
  always_comb begin
    valid_d = in_valid;
    diff_d  = diff_q;
    flags_d = flags_q;
    if (in_valid) begin
      diff_d  = diff_c;
      flags_d = flags_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      diff_q  <= diff_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign diff      = diff_q;
  assign n_flag    = flags_q.n;
  assign z_flag    = flags_q.z;
  assign v_flag    = flags_q.v;

endmodule

// File: tb/tb_subtractor_reg.sv
// Self-checking bench for subtractor_reg: directed table, reset corner cases,
// exhaustive operand sweep and randomized traffic against an arithmetic model.
module tb_subtractor_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       out_valid;
  logic [3:0] diff;
  logic       n_flag;
  logic       z_flag;
  logic       v_flag;

  int nChecks = 0;
  int nFails  = 0;

  // expected registered state, maintained from the arithmetic model
  logic       expValid;
  logic [3:0] expDiff;
  logic       expN, expZ, expV;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eDiff;
    logic       eN;
    logic       eZ;
    logic       eV;
  } vec_t;

  vec_t vecs[7];

  subtractor_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .diff      (diff),
    .n_flag    (n_flag),
    .z_flag    (z_flag),
    .v_flag    (v_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference computed with plain integer arithmetic on the operand values.
  function automatic logic [6:0] refModel(input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, d, sd;
    logic [3:0] rd;
    logic rn, rz, rv;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    d  = ua - ub;
    if (d < 0) d = d + 16;
    rd = 4'(d);
    rn = (ub > ua);
    rz = (d == 0);
    sd = sa - sb;
    rv = (sd > 7) || (sd < -8);
    return {rd, rn, rz, rv};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(expValid));
    checkOutput({tag, " diff"},      32'(diff),      32'(expDiff));
    checkOutput({tag, " n_flag"},    32'(n_flag),    32'(expN));
    checkOutput({tag, " z_flag"},    32'(z_flag),    32'(expZ));
    checkOutput({tag, " v_flag"},    32'(v_flag),    32'(expV));
  endtask

  // Drive one cycle of operands, confirm nothing changes before the edge,
  // then confirm the model's result right after the edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] a,
                               input logic [3:0] b);
    logic [6:0] r;
    @(negedge clk);
    in_valid = v;
    in1      = a;
    in2      = b;
    #1;
    checkOutput({tag, " pre-edge diff"},      32'(diff),      32'(expDiff));
    checkOutput({tag, " pre-edge out_valid"}, 32'(out_valid), 32'(expValid));
    @(posedge clk);
    #1;
    expValid = v;
    if (v) begin
      r = refModel(a, b);
      {expDiff, expN, expZ, expV} = r;
    end
    checkAll(tag);
  endtask

  task automatic clearModel();
    expValid = 1'b0;
    expDiff  = 4'd0;
    expN     = 1'b0;
    expZ     = 1'b0;
    expV     = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd4,  4'd3,  4'd1,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd4,  4'd5,  4'd15, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'd15, 4'd8,  4'd7,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'd8,  4'd15, 4'd9,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'd7,  4'd8,  4'd15, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = 4'd0;
    in2      = 4'd0;
    clearModel();

    #2;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // directed table: check against the hand-derived expected values
    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), 1'b1, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d table diff", i), 32'(diff),   32'(vecs[i].eDiff));
      checkOutput($sformatf("vec%0d table n", i),    32'(n_flag), 32'(vecs[i].eN));
      checkOutput($sformatf("vec%0d table z", i),    32'(z_flag), 32'(vecs[i].eZ));
      checkOutput($sformatf("vec%0d table v", i),    32'(v_flag), 32'(vecs[i].eV));
    end

    // 0 - 15 wraps to 1 with a borrow
    applyStimulus("zero_minus_max", 1'b1, 4'd0, 4'd15);
    checkOutput("zero_minus_max diff", 32'(diff),   32'd1);
    checkOutput("zero_minus_max n",    32'(n_flag), 32'd1);

    // idle cycles hold the previous result with out_valid low
    applyStimulus("hold0", 1'b0, 4'd9, 4'd3);
    applyStimulus("hold1", 1'b0, 4'd2, 4'd14);
    checkOutput("hold diff kept", 32'(diff), 32'd1);

    // asynchronous reset in the middle of a valid cycle discards that result
    applyStimulus("pre_reset", 1'b1, 4'd9, 4'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in1      = 4'd3;
    in2      = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    clearModel();
    checkAll("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    applyStimulus("post_reset_idle", 1'b0, 4'd6, 4'd6);
    checkOutput("post_reset diff held zero", 32'(diff), 32'd0);
    applyStimulus("post_reset_first", 1'b1, 4'd3, 4'd1);

    // exhaustive back-to-back sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus($sformatf("sweep_%0d_%0d", a, b), 1'b1, 4'(a), 4'(b));
      end
    end

    // randomized traffic with random idle cycles
    for (int k = 0; k < 300; k++) begin
      applyStimulus($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
